z_deserializer: RTL and testbench

Z_DESERIALIZER -- requirements
Module: z_deserializer

---
 rtl/z_deserializer_if.sv | 22 ++
 rtl/z_deserializer.sv | 105 ++++++++++
 tb/tb_z_deserializer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/z_deserializer_if.sv
// Bus bundle between the serial producer/consumer and z_deserializer.
// Signal prefixes are from the deserializer's point of view.
interface z_deserializer_if;
    logic       i_z;
    logic       i_sample;
    logic       i_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic [3:0] o_ones_count;
    logic       o_overrun;
    logic [2:0] o_bit_index;

    modport slave (
        input  i_z, i_sample, i_ready,
        output o_data, o_valid, o_ones_count, o_overrun, o_bit_index
    );

    modport master (
        output i_z, i_sample, i_ready,
        input  o_data, o_valid, o_ones_count, o_overrun, o_bit_index
    );
endinterface

// File: rtl/z_deserializer.sv
// LSB-first 8-bit deserializer for a sampled serial bit stream, with a
// one-word valid/ready holding stage, popcount and sticky overrun flag.
module z_deserializer (
    input  logic              clk,
    input  logic              rst,
    z_deserializer_if.slave   bus
);
    localparam int unsigned W  = 8;
    localparam int unsigned IW = 3;
    localparam int unsigned CW = 4;

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [W-1:0]    r_shift;
    logic [IW-1:0]   r_bit_index;
    logic [W-1:0]    r_data;
    logic [CW-1:0]   r_ones_count;
    logic            r_overrun;

    logic            w_complete;
    logic            w_load;
    logic            w_drop;
    logic [W-1:0]    w_word;

    function automatic logic [CW-1:0] popcount(input logic [W-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < int'(W); i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    assign w_complete = bus.i_sample && (r_bit_index == IW'(W - 1));

    // Completed word includes the bit arriving on this very edge.
    always_comb begin
        w_word        = r_shift;
        w_word[W-1]   = bus.i_z;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_EMPTY: if (w_complete)  w_next_state = S_FULL;
            S_FULL:  if (!w_complete && bus.i_ready) w_next_state = S_EMPTY;
            default: w_next_state = S_EMPTY;
        endcase
    end

    always_comb begin
        w_load = 1'b0;
        w_drop = 1'b0;
        case (r_state)
            S_EMPTY: w_load = w_complete;
            S_FULL: begin
                w_load = w_complete && bus.i_ready;
                w_drop = w_complete && !bus.i_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift     <= '0;
            r_bit_index <= '0;
        end else if (bus.i_sample) begin
            r_shift[r_bit_index] <= bus.i_z;
            r_bit_index          <= r_bit_index + IW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data       <= '0;
            r_ones_count <= '0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_load) begin
                r_data       <= w_word;
                r_ones_count <= popcount(w_word);
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign bus.o_data       = r_data;
    assign bus.o_ones_count = r_ones_count;
    assign bus.o_overrun    = r_overrun;
    assign bus.o_bit_index  = r_bit_index;
    assign bus.o_valid      = (r_state == S_FULL);
endmodule

// File: tb/tb_z_deserializer.sv
// Scoreboard bench for z_deserializer: directed scenarios plus random
// stimulus checked against a bit-queue reference model.
module tb_z_deserializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    z_deserializer_if bus();

    z_deserializer u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: captured bits, held word, sticky flag, expected words.
    logic [7:0] exp_q[$];
    bit         m_bits[$];
    bit         m_valid = 1'b0;
    bit         m_ovr   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_bits.delete();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // Drive one cycle of inputs and predict the state after the next edge.
    task automatic step(input bit z, input bit s, input bit r);
        logic [7:0] w;
        bit done;
        @(negedge clk);
        bus.i_z      = z;
        bus.i_sample = s;
        bus.i_ready  = r;
        done = 1'b0;
        w    = '0;
        if (s) begin
            m_bits.push_back(z);
            if (m_bits.size() == 8) begin
                foreach (m_bits[i]) w = w | (8'(m_bits[i]) << i);
                m_bits.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            if (!m_valid || r) begin
                m_valid = 1'b1;
                exp_q.push_back(w);
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic send_word(input logic [7:0] w, input bit r);
        for (int i = 0; i < 8; i++) step(w[i], 1'b1, r);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        bus.i_sample = 1'b0;
        bus.i_ready  = 1'b0;
        model_reset();
        #1;
        check("async_rst_valid",   32'(bus.o_valid),        32'd0);
        check("async_rst_data",    32'(bus.o_data),         32'd0);
        check("async_rst_ones",    32'(bus.o_ones_count),   32'd0);
        check("async_rst_overrun", 32'(bus.o_overrun),      32'd0);
        check("async_rst_bitidx",  32'(bus.o_bit_index),    32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compare a newly presented word against the scoreboard,
    // and the status outputs against the model on every edge.
    initial begin
        logic       pv;
        logic       ph;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            #4;
            pv = bus.o_valid;
            ph = bus.o_valid && bus.i_ready;
            @(posedge clk);
            #1;
            if (!rst) begin
                if (bus.o_valid && (!pv || ph)) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_unexpected_word: got 0x%0h expected none at %0t", bus.o_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_data", 32'(bus.o_data), 32'(e));
                        check("sb_ones", 32'(bus.o_ones_count), 32'($countones(e)));
                    end
                end
                check("mon_valid",   32'(bus.o_valid),     32'(m_valid));
                check("mon_overrun", 32'(bus.o_overrun),   32'(m_ovr));
                check("mon_bitidx",  32'(bus.o_bit_index), 32'(m_bits.size()));
            end
        end
    end

    initial begin
        bus.i_z      = 1'b0;
        bus.i_sample = 1'b0;
        bus.i_ready  = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("por_valid",   32'(bus.o_valid),   32'd0);
        check("por_data",    32'(bus.o_data),    32'd0);
        check("por_overrun", 32'(bus.o_overrun), 32'd0);
        check("por_bitidx",  32'(bus.o_bit_index), 32'd0);
        rst = 1'b0;

        // Basic word 1,0,1,1,0,0,0,1 with no consumer.
        send_word(8'h8D, 1'b0);
        settle();
        check("basic_valid",  32'(bus.o_valid),        32'd1);
        check("basic_data",   32'(bus.o_data),         32'h8D);
        check("basic_ones",   32'(bus.o_ones_count),   32'd4);
        check("basic_bitidx", 32'(bus.o_bit_index),    32'd0);

        // Drain: valid drops, data holds.
        step(1'b0, 1'b0, 1'b1);
        settle();
        check("drain_valid",   32'(bus.o_valid),   32'd0);
        check("drain_data",    32'(bus.o_data),    32'h8D);
        check("drain_overrun", 32'(bus.o_overrun), 32'd0);

        // Gapped sampling: three idle cycles between bits 3 and 4.
        for (int i = 0; i < 4; i++) step(1'(8'h8D >> i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'($urandom_range(1)), 1'b0, 1'b0);
        for (int i = 4; i < 7; i++) step(1'(8'h8D >> i), 1'b1, 1'b0);
        settle();
        check("gap_not_yet_valid", 32'(bus.o_valid), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        settle();
        check("gap_valid", 32'(bus.o_valid), 32'd1);
        check("gap_data",  32'(bus.o_data),  32'h8D);
        step(1'b0, 1'b0, 1'b1);

        // Back-to-back with ready held high.
        send_word(8'hFF, 1'b1);
        send_word(8'h00, 1'b1);
        settle();
        check("b2b_valid",   32'(bus.o_valid),      32'd1);
        check("b2b_data",    32'(bus.o_data),       32'h00);
        check("b2b_ones",    32'(bus.o_ones_count), 32'd0);
        check("b2b_overrun", 32'(bus.o_overrun),    32'd0);
        step(1'b0, 1'b0, 1'b1);

        // Overrun: second word dropped, flag sticky through a drain.
        send_word(8'hA5, 1'b0);
        send_word(8'h3C, 1'b0);
        settle();
        check("ovr_data",    32'(bus.o_data),       32'hA5);
        check("ovr_ones",    32'(bus.o_ones_count), 32'd4);
        check("ovr_flag",    32'(bus.o_overrun),    32'd1);
        step(1'b0, 1'b0, 1'b1);
        settle();
        check("ovr_sticky",       32'(bus.o_overrun), 32'd1);
        check("ovr_drained_valid", 32'(bus.o_valid),  32'd0);

        // Async reset mid-word, then a fresh word from bit 0.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        async_reset();
        send_word(8'h0F, 1'b0);
        settle();
        check("post_rst_data",  32'(bus.o_data),       32'h0F);
        check("post_rst_ones",  32'(bus.o_ones_count), 32'd4);
        check("post_rst_valid", 32'(bus.o_valid),      32'd1);

        // Reset while FULL discards the held word.
        async_reset();
        settle();
        check("rst_full_valid", 32'(bus.o_valid), 32'd0);

        // Random traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(199) == 0) begin
                async_reset();
            end else begin
                step(1'($urandom_range(1)),
                     ($urandom_range(9) < 7),
                     ($urandom_range(9) < 4));
            end
        end
        step(1'b0, 1'b0, 1'b0);
        settle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
